// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one pipelined memory port between the D-cache
// (channel 0) and the I-cache (channel 1). A write-through request occupies a
// single WRITE cycle; a block fill streams WORDS_PER_BLOCK word reads and writes
// each returning word straight into the granted cache's data array, with the
// tag written alongside the last word.
// Build option: define MEM_FILL_ARBITER_RR_EN for round-robin arbitration;
// left undefined, arbitration is fixed priority with the lowest index winning.
module mem_fill_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]          req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]          req_wdata,
    output logic [NUM_REQ-1:0]                 done,
    output logic [NUM_REQ-1:0]                 stall,
    output logic [NUM_REQ-1:0]                 fill_data_we,
    output logic [NUM_REQ-1:0]                 fill_tag_we,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic [DATA_W-1:0]                  fill_data,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    input  logic [DATA_W-1:0]                  mem_rdata,
    input  logic                               mem_valid
);

    localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [WORD_W:0]   NUM_WORDS = (WORD_W + 1)'(WORDS_PER_BLOCK);
    localparam logic [WORD_W-1:0] LAST_WORD = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;

    // Control state
    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_gnt;
    logic [WORD_W:0]   r_issue;
    logic [WORD_W-1:0] r_rcv;

    // Operation operands captured at grant time
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic               w_any_req;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [NUM_REQ-1:0] w_req_oh;
    logic               w_sel_wr;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_issue_en;
    logic               w_last;
    logic               w_done_any;
    logic               w_data_we_any;
    logic               w_tag_we_any;
    logic [NUM_REQ-1:0] w_gnt_oh;

    assign w_any_req = |req_valid;

`ifdef MEM_FILL_ARBITER_RR_EN
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_rr_idx;
    logic             w_found;

    // Round-robin pick: search begins one past the most recently granted channel
    always_comb begin
        w_gnt_idx = '0;
        w_found   = 1'b0;
        w_rr_idx  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_rr_idx = IDX_W'((int'(r_last) + 1 + j) % NUM_REQ);
            if (!w_found && (|(req_valid & (NUM_REQ'(1) << w_rr_idx)))) begin
                w_found   = 1'b1;
                w_gnt_idx = w_rr_idx;
            end
        end
    end

    // Remember the last winner; after reset the search starts at channel 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= IDX_W'(NUM_REQ - 1);
        end else if ((r_state == S_IDLE) && w_any_req) begin
            r_last <= w_gnt_idx;
        end
    end
`else
    logic [NUM_REQ-1:0] w_lowest;

    // Fixed priority pick: isolate the lowest requesting channel and encode it
    always_comb begin
        w_lowest  = req_valid & (~req_valid + NUM_REQ'(1));
        w_gnt_idx = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_lowest == (NUM_REQ'(1) << j)) begin
                w_gnt_idx = IDX_W'(j);
            end
        end
    end
`endif

    assign w_req_oh    = NUM_REQ'(1) << w_gnt_idx;
    assign w_sel_wr    = |(req_wr & w_req_oh);
    assign w_sel_addr  = ADDR_W'(req_addr >> (ADDR_W * int'(w_gnt_idx)));
    assign w_sel_wdata = DATA_W'(req_wdata >> (DATA_W * int'(w_gnt_idx)));

    // Issue side runs ahead of the return side; both share the FILL state
    assign w_issue_en = (r_state == S_FILL) && (r_issue < NUM_WORDS);
    assign w_last     = (r_state == S_FILL) && mem_valid && (r_rcv == LAST_WORD);

    // Operation FSM with issue and receive counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_issue <= '0;
            r_rcv   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_issue <= '0;
                    r_rcv   <= '0;
                    if (w_any_req) begin
                        r_gnt   <= w_gnt_idx;
                        r_state <= w_sel_wr ? S_WRITE : S_FILL;
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                end
                S_FILL: begin
                    if (w_issue_en) begin
                        r_issue <= r_issue + 1'b1;
                    end
                    if (mem_valid) begin
                        r_rcv <= r_rcv + 1'b1;
                    end
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Latch the winner's address and write data; held for the whole operation
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && w_any_req) begin
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    // Memory-side and cache-side strobes; everything is held quiet while rst is high
    always_comb begin
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        fill_word     = '0;
        w_done_any    = 1'b0;
        w_data_we_any = 1'b0;
        w_tag_we_any  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_WRITE: begin
                    mem_en     = 1'b1;
                    mem_wr     = 1'b1;
                    mem_addr   = r_addr;
                    mem_wdata  = r_wdata;
                    w_done_any = 1'b1;
                end
                S_FILL: begin
                    if (w_issue_en) begin
                        mem_en   = 1'b1;
                        mem_addr = {r_addr[ADDR_W-1:WORD_W+1], r_issue[WORD_W-1:0], 1'b0};
                    end
                    if (mem_valid) begin
                        w_data_we_any = 1'b1;
                        fill_word     = r_rcv;
                    end
                    if (w_last) begin
                        w_tag_we_any = 1'b1;
                        w_done_any   = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_gnt_oh     = NUM_REQ'(1) << r_gnt;
    assign done         = w_done_any    ? w_gnt_oh : '0;
    assign fill_data_we = w_data_we_any ? w_gnt_oh : '0;
    assign fill_tag_we  = w_tag_we_any  ? w_gnt_oh : '0;
    assign fill_data    = mem_rdata;
    assign stall        = req_valid & ~done;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench for mem_fill_arbiter (NUM_REQ=2, 8-word blocks, memory
// latency 4). Stimulus pushes cycle-stamped expected memory-side and cache-side
// events; a monitor on the falling edge pops and compares them.
module tb_mem_fill_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  done;
    logic [1:0]  stall;
    logic [1:0]  fill_data_we;
    logic [1:0]  fill_tag_we;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;

    mem_fill_arbiter #(
        .NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .stall(stall), .fill_data_we(fill_data_we), .fill_tag_we(fill_tag_we),
        .fill_word(fill_word), .fill_data(fill_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Memory model: four-stage read pipeline, cleared by the shared reset
    logic [3:0]  pv;
    logic [15:0] pa0, pa1, pa2, pa3;
    logic        stray;
    always @(posedge clk) begin
        if (rst) pv <= 4'b0000;
        else     pv <= {pv[2:0], mem_en & ~mem_wr};
        pa0 <= mem_addr;
        pa1 <= pa0;
        pa2 <= pa1;
        pa3 <= pa2;
    end
    assign mem_valid = pv[3] | stray;
    assign mem_rdata = mem_fn(pa3);

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_ev_t;

    typedef struct {
        int          cyc;
        logic [1:0]  we;
        logic [1:0]  tag;
        logic [1:0]  dn;
        logic [2:0]  word;
        logic [15:0] data;
    } c_ev_t;

    mem_ev_t mq[$];
    c_ev_t   cq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;   // 0: events only, 1: also require quiet, 2: zero outputs under rst
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    task automatic push_write(input int ch, input logic [15:0] a, input logic [15:0] d, input int t0);
        mem_ev_t m;
        c_ev_t   c;
        m.cyc = t0 + 1; m.wr = 1'b1; m.addr = a; m.wdata = d;
        mq.push_back(m);
        c.cyc = t0 + 1; c.we = 2'b00; c.tag = 2'b00; c.dn = 2'b01 << ch; c.word = 3'd0; c.data = 16'h0;
        cq.push_back(c);
    endtask

    task automatic push_fill(input int ch, input logic [15:0] base, input int t0, input int nm, input int nc);
        mem_ev_t    m;
        c_ev_t      c;
        logic [1:0] oh;
        oh = 2'b01 << ch;
        for (int k = 0; k < nm; k++) begin
            m.cyc = t0 + 1 + k; m.wr = 1'b0; m.addr = base + 16'(2 * k); m.wdata = 16'h0;
            mq.push_back(m);
        end
        for (int k = 0; k < nc; k++) begin
            c.cyc  = t0 + 5 + k;
            c.we   = oh;
            c.tag  = (k == 7) ? oh : 2'b00;
            c.dn   = (k == 7) ? oh : 2'b00;
            c.word = 3'(k);
            c.data = mem_fn(base + 16'(2 * k));
            cq.push_back(c);
        end
    endtask

    task automatic set_req(input int ch, input logic wr, input logic [15:0] a, input logic [15:0] d);
        if (ch == 0) begin
            req_addr[15:0]  = a;
            req_wdata[15:0] = d;
        end else begin
            req_addr[31:16]  = a;
            req_wdata[31:16] = d;
        end
        req_wr    = (req_wr & ~(2'b01 << ch)) | (wr ? (2'b01 << ch) : 2'b00);
        req_valid = req_valid | (2'b01 << ch);
    endtask

    // One clock: requesters drop req_valid right after the cycle their done pulsed
    task automatic step();
        logic [1:0] d;
        @(negedge clk);
        d = done;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~d;
    endtask

    task automatic wait_release(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (req_valid == 2'b00) break;
            step();
        end
        step();
        step();
    endtask

    // Monitor / scoreboard
    initial begin
        mem_ev_t m;
        c_ev_t   c;
        forever begin
            @(negedge clk);
            if (end_req) begin
                if (!end_ack) begin
                    n_cmp++;
                    if (mq.size() != 0 || cq.size() != 0) begin
                        n_bad++;
                        $display("FAIL leftover: got %0d mem / %0d cache events unseen, need 0 / 0", mq.size(), cq.size());
                    end
                    end_ack = 1'b1;
                end
            end else if (rst) begin
                if (mode == 2) begin
                    n_cmp++;
                    if ({mem_en, mem_wr, mem_addr, mem_wdata, fill_word, fill_data_we, fill_tag_we, done, stall} != '0) begin
                        n_bad++;
                        $display("FAIL reset_zero @%0d: got en=%0b wr=%0b addr=%h wdata=%h word=%0d we=%b tag=%b done=%b stall=%b, need all zero",
                                 cyc, mem_en, mem_wr, mem_addr, mem_wdata, fill_word, fill_data_we, fill_tag_we, done, stall);
                    end
                end
            end else begin
                while (mq.size() > 0 && mq[0].cyc < cyc) begin
                    m = mq.pop_front();
                    n_cmp++; n_bad++;
                    $display("FAIL mem_missing @%0d: got nothing, need addr=%h wr=%0b at cycle %0d", cyc, m.addr, m.wr, m.cyc);
                end
                if (mq.size() > 0 && mq[0].cyc == cyc) begin
                    m = mq.pop_front();
                    n_cmp++;
                    if (!(mem_en === 1'b1 && mem_wr === m.wr && mem_addr === m.addr && (!m.wr || mem_wdata === m.wdata))) begin
                        n_bad++;
                        $display("FAIL mem_ev @%0d: got en=%0b wr=%0b addr=%h wdata=%h, need en=1 wr=%0b addr=%h wdata=%h",
                                 cyc, mem_en, mem_wr, mem_addr, mem_wdata, m.wr, m.addr, m.wdata);
                    end
                end else if (mem_en !== 1'b0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL mem_unexpected @%0d: got en=%0b addr=%h, need en=0", cyc, mem_en, mem_addr);
                end

                while (cq.size() > 0 && cq[0].cyc < cyc) begin
                    c = cq.pop_front();
                    n_cmp++; n_bad++;
                    $display("FAIL cache_missing @%0d: got nothing, need we=%b word=%0d done=%b at cycle %0d", cyc, c.we, c.word, c.dn, c.cyc);
                end
                if (cq.size() > 0 && cq[0].cyc == cyc) begin
                    c = cq.pop_front();
                    n_cmp++;
                    if (!(fill_data_we === c.we && fill_tag_we === c.tag && done === c.dn &&
                          (c.we == 2'b00 || (fill_word === c.word && fill_data === c.data)))) begin
                        n_bad++;
                        $display("FAIL cache_ev @%0d: got we=%b tag=%b done=%b word=%0d data=%h, need we=%b tag=%b done=%b word=%0d data=%h",
                                 cyc, fill_data_we, fill_tag_we, done, fill_word, fill_data, c.we, c.tag, c.dn, c.word, c.data);
                    end
                    n_cmp++;
                    if (stall !== (req_valid & ~done)) begin
                        n_bad++;
                        $display("FAIL stall @%0d: got %b, need %b", cyc, stall, req_valid & ~done);
                    end
                end else if ({fill_data_we, fill_tag_we, done} !== 6'b0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL cache_unexpected @%0d: got we=%b tag=%b done=%b, need all 0", cyc, fill_data_we, fill_tag_we, done);
                end

                if (mode == 1) begin
                    n_cmp++;
                    if ({mem_en, mem_wr, fill_data_we, fill_tag_we, done, stall} !== 8'b0) begin
                        n_bad++;
                        $display("FAIL quiet @%0d: got en=%0b wr=%0b we=%b tag=%b done=%b stall=%b, need all 0",
                                 cyc, mem_en, mem_wr, fill_data_we, fill_tag_we, done, stall);
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int t0;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_wr    = 2'b00;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        stray     = 1'b0;

        @(posedge clk);
        #1;
        mode = 2;
        repeat (3) step();
        rst  = 1'b0;
        mode = 1;
        step();
        step();
        mode = 0;

        // Single write-through on the D-cache channel
        t0 = cyc;
        set_req(0, 1'b1, 16'h0040, 16'hBEEF);
        push_write(0, 16'h0040, 16'hBEEF, t0);
        wait_release(10);

        // I-cache block fill from a mid-block address
        t0 = cyc;
        set_req(1, 1'b0, 16'h1236, 16'h0);
        push_fill(1, 16'h1230, t0, 8, 8);
        wait_release(30);

        // Simultaneous fills: channel 0 first, channel 1 after one idle cycle
        t0 = cyc;
        set_req(0, 1'b0, 16'h3008, 16'h0);
        set_req(1, 1'b0, 16'h4FFF, 16'h0);
        push_fill(0, 16'h3000, t0, 8, 8);
        push_fill(1, 16'h4FF0, t0 + 13, 8, 8);
        wait_release(60);

        // Conflicting writes with channel 0 re-requesting straight away
        t0 = cyc;
        set_req(0, 1'b1, 16'h0100, 16'h1111);
        set_req(1, 1'b1, 16'h0200, 16'h2222);
        push_write(0, 16'h0100, 16'h1111, t0);
`ifdef MEM_FILL_ARBITER_RR_EN
        push_write(1, 16'h0200, 16'h2222, t0 + 2);
        push_write(0, 16'h0102, 16'h3333, t0 + 4);
`else
        push_write(0, 16'h0102, 16'h3333, t0 + 2);
        push_write(1, 16'h0200, 16'h2222, t0 + 4);
`endif
        step();
        step();
        set_req(0, 1'b1, 16'h0102, 16'h3333);
        wait_release(20);

        // Reset in the middle of a fill, after the third returned word
        t0 = cyc;
        set_req(0, 1'b0, 16'h2004, 16'h0);
        push_fill(0, 16'h2000, t0, 7, 3);
        repeat (8) step();
        rst       = 1'b1;
        req_valid = 2'b00;
        step();
        rst  = 1'b0;
        mode = 1;
        step();
        mode = 0;

        // Fresh fill after the reset starts again at word 0
        t0 = cyc;
        set_req(0, 1'b0, 16'h2010, 16'h0);
        push_fill(0, 16'h2010, t0, 8, 8);
        wait_release(30);

        // Requester withdraws mid-fill; the fill still completes
        t0 = cyc;
        set_req(1, 1'b0, 16'h0A1E, 16'h0);
        push_fill(1, 16'h0A10, t0, 8, 8);
        repeat (3) step();
        req_valid = 2'b00;
        repeat (12) step();
        step();
        step();

        // Stray mem_valid while idle
        mode  = 1;
        stray = 1'b1;
        step();
        step();
        stray = 1'b0;
        step();
        mode = 0;
        step();

        end_req = 1'b1;
        for (int n = 0; n < 5 && !end_ack; n++) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_fill_arbiter.md
MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 Parameter NUM_REQ, 2, number of cache requester channels (index 0 = D-cache, 1 = I-cache).
REQ-002 Parameter ADDR_W, 16, byte address width.
REQ-003 Parameter DATA_W, 16, word width.
REQ-004 Parameter WORDS_PER_BLOCK, 8, words per cache block (power of two, 2..64).
REQ-005 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Port rst  in  1  synchronous active-high reset.
REQ-007 Port req_valid  in  NUM_REQ  per-channel request; held high until matching done pulse.
REQ-008 Port req_wr  in  NUM_REQ  per-channel type: 1 = single-word write-through, 0 = block fill.
REQ-009 Port req_addr  in  NUM_REQ*ADDR_W  per-channel byte address, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-010 Port req_wdata  in  NUM_REQ*DATA_W  per-channel write data, same packing.
REQ-011 Port done  out  NUM_REQ  one-cycle completion pulse to granted channel.
REQ-012 Port stall  out  NUM_REQ  stall[i] = req_valid[i] & ~done[i].
REQ-013 Port fill_data_we  out  NUM_REQ  data-array write strobe to granted cache.
REQ-014 Port fill_tag_we  out  NUM_REQ  tag-array write strobe to granted cache.
REQ-015 Port fill_word  out  log2(WORDS_PER_BLOCK)  word index written this cycle.
REQ-016 Port fill_data  out  DATA_W  word to write, equals mem_rdata.
REQ-017 Port mem_en, mem_wr  out  1 each  memory enable / write.
REQ-018 Port mem_addr, mem_wdata  out  ADDR_W, DATA_W  memory address / write data.
REQ-019 Port mem_rdata, mem_valid  in  DATA_W, 1  pipelined memory read data and valid (fixed latency, one address accepted per cycle).

Function
REQ-020 FSM states IDLE, WRITE, FILL; shall leave IDLE only when some req_valid is high.
REQ-021 In IDLE, arbiter shall register granted index, address, data and type; next state WRITE if req_wr else FILL.
REQ-022 Default arbitration: fixed priority, lowest index wins.
REQ-023 Grant captured values shall be used for the whole operation; dropping req_valid mid-operation shall not abort it.
REQ-024 WRITE: one cycle, mem_en=1, mem_wr=1, mem_addr/mem_wdata = captured values, done[g]=1, then IDLE.
REQ-025 FILL: base = captured addr with low log2(2*WORDS_PER_BLOCK) bits cleared; issue counter drives mem_addr = base + 2*k, mem_en=1, mem_wr=0 for k = 0..WORDS_PER_BLOCK-1 on consecutive cycles, then mem_en=0.
REQ-026 Receive counter shall increment on each mem_valid in FILL; that cycle fill_data_we[g]=1, fill_word = counter, fill_data = mem_rdata.
REQ-027 On last received word, fill_tag_we[g]=1 and done[g]=1 in same cycle; next state IDLE.
REQ-028 mem_valid outside FILL shall be ignored; no strobes asserted.
REQ-029 At least one IDLE cycle between operations; a request arriving during done is arbitrated in that IDLE cycle.
REQ-030 Non-granted channels shall see all strobes and done low.

Reset
REQ-031 rst high at any edge, including mid-FILL, shall force IDLE, clear counters and grant, drive done, fill_data_we, fill_tag_we, mem_en, mem_wr low and fill_word, mem_addr, mem_wdata zero; memory shares rst so stale mem_valid cannot follow.

Configuration
REQ-032 Macro MEM_FILL_ARBITER_RR_EN defined: round-robin arbitration, search starts at last granted index +1 (mod NUM_REQ), pointer resets to NUM_REQ-1; undefined: fixed priority per REQ-022.

Verification (NUM_REQ=2, WORDS_PER_BLOCK=8, memory latency 4)
REQ-033 Fill ch1 addr 0x1236 -> mem_addr 0x1230..0x123E over 8 cycles; 8 fill_data_we[1] pulses, fill_word 0..7; fill_tag_we[1] and done[1] on 8th valid.
REQ-034 Write ch0 addr 0x0040 data 0xBEEF -> one cycle mem_en=1 mem_wr=1 addr 0x0040 data 0xBEEF, done[0] one cycle after request seen in IDLE.
REQ-035 Both fill requests same cycle, fixed priority -> ch0 served first, ch1 starts after one IDLE cycle; with RR_EN and two back-to-back conflicts, grants alternate 0,1,0,1.
REQ-036 rst asserted after 3rd fill word -> next cycle IDLE, all strobes low; new fill completes with fill_word starting at 0.
REQ-037 req_valid dropped mid-fill -> fill still completes with done pulse; stray mem_valid in IDLE -> no strobes.
